tl_buffer_param: RTL and testbench

// - Parametrised TileLink-UL buffer between a client (in) and a manager (out) port.
// - Inserts an independently sized queue on the A channel (in->out) and the D channel (out->in).
// - Each queue has its own depth, flow and pipe options, and reports its occupancy.
// - D param/sink/denied/corrupt are carried end to end; nothing is tied off.
// - Replaces the fixed 2-entry buffers on the tile-to-bus crossings.

---
 rtl/tl_buffer_pkg.sv | 58 +++++
 rtl/tl_buffer_param_queue.sv | 91 +++++++++
 rtl/tl_buffer_param.sv | 98 +++++++++
 tb/tb_tl_buffer_param.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_buffer_pkg.sv
// Shared TileLink-UL definitions for the tile-to-bus buffer: field widths,
// opcode constants, beat structs at the default widths and width helpers.
package tl_buffer_pkg;

    localparam int TL_ADDR_W   = 32;
    localparam int TL_DATA_W   = 64;
    localparam int TL_SOURCE_W = 10;
    localparam int TL_SIZE_W   = 2;
    localparam int TL_SINK_W   = 1;

    localparam logic [2:0] TL_A_PUT_FULL        = 3'd0;
    localparam logic [2:0] TL_A_PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] TL_A_GET             = 3'd4;
    localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;

    // A beat at the default widths; a module with other widths builds the
    // same field order from its own parameters.
    typedef struct packed {
        logic [2:0]               opcode;
        logic [2:0]               param;
        logic [TL_SIZE_W-1:0]     size;
        logic [TL_SOURCE_W-1:0]   source;
        logic [TL_ADDR_W-1:0]     address;
        logic [TL_DATA_W/8-1:0]   mask;
        logic [TL_DATA_W-1:0]     data;
        logic                     corrupt;
    } tl_a_t;

    // D beat at the default widths.
    typedef struct packed {
        logic [2:0]               opcode;
        logic [1:0]               param;
        logic [TL_SIZE_W-1:0]     size;
        logic [TL_SOURCE_W-1:0]   source;
        logic [TL_SINK_W-1:0]     sink;
        logic                     denied;
        logic [TL_DATA_W-1:0]     data;
        logic                     corrupt;
    } tl_d_t;

    function automatic int tl_a_width(input int addr_w, input int data_w,
                                      input int source_w, input int size_w);
        return 3 + 3 + size_w + source_w + addr_w + data_w / 8 + data_w + 1;
    endfunction

    function automatic int tl_d_width(input int data_w, input int source_w,
                                      input int size_w, input int sink_w);
        return 3 + 2 + size_w + source_w + sink_w + 1 + data_w + 1;
    endfunction

    // Occupancy counter width; a wire-through queue still gets one bit
    // (always zero) so the port never collapses to zero width.
    function automatic int tl_count_width(input int depth);
        return (depth == 0) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/tl_buffer_param_queue.sv
// Register-array FIFO carrying one TileLink channel. DEPTH=0 is a pure
// wire-through; FLOW lets a beat skip storage when empty; PIPE lets a full
// queue accept a beat in the same cycle one leaves.
module tl_queue
    import tl_buffer_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter int  FLOW  = 0,
    parameter int  PIPE  = 0,
    parameter type T     = logic [7:0]
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enq_valid,
    output logic                             enq_ready,
    input  T                                 enq_bits,
    output logic                             deq_valid,
    input  logic                             deq_ready,
    output T                                 deq_bits,
    output logic [tl_count_width(DEPTH)-1:0] count
);

    localparam int CW = tl_count_width(DEPTH);
    localparam int PW = (DEPTH <= 1) ? 1 : $clog2(DEPTH);

    // Pointers wrap at DEPTH-1 so non-power-of-two depths use every entry.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        if (ptr == PW'(DEPTH - 1)) return '0;
        return ptr + 1'b1;
    endfunction

    if (DEPTH == 0) begin : g_wire
        assign deq_valid = enq_valid;
        assign enq_ready = deq_ready;
        assign deq_bits  = enq_bits;
        assign count     = '0;
    end else begin : g_fifo
        T              mem [DEPTH];
        logic [PW-1:0] head;
        logic [PW-1:0] tail;
        logic          empty;
        logic          full;
        logic          enq_fire;
        logic          deq_fire;
        logic          bypass;
        logic          do_write;
        logic          do_read;

        assign empty = (count == '0);
        assign full  = (count == CW'(DEPTH));

        // Readys are held low through reset so no beat is taken on the reset edge.
        assign enq_ready = !rst && (!full || ((PIPE != 0) && deq_ready));
        assign deq_valid = !rst && (!empty || ((FLOW != 0) && enq_valid));
        assign deq_bits  = ((FLOW != 0) && empty) ? enq_bits : mem[head];

        assign enq_fire = enq_valid && enq_ready;
        assign deq_fire = deq_valid && deq_ready;
        // A flow-through beat consumed in its arrival cycle never touches storage.
        assign bypass   = (FLOW != 0) && empty && enq_fire && deq_fire;
        assign do_write = enq_fire && !bypass;
        assign do_read  = deq_fire && !bypass;

        // Pointer and occupancy update; held beats are dropped on reset.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (do_write) tail <= ptr_inc(tail);
                if (do_read)  head <= ptr_inc(head);
                if (do_write && !do_read)      count <= count + 1'b1;
                else if (!do_write && do_read) count <= count - 1'b1;
            end
        end

        // Storage is deliberately left unreset; entries are only read once written.
        always_ff @(posedge clk) begin
            if (do_write) mem[tail] <= enq_bits;
        end

        a_count_bound : assert property (@(posedge clk) disable iff (rst)
            count <= CW'(DEPTH));
        a_no_underflow : assert property (@(posedge clk) disable iff (rst)
            deq_fire |-> (!empty || ((FLOW != 0) && enq_valid)));
        a_bits_stable : assert property (@(posedge clk) disable iff (rst)
            (enq_valid && !enq_ready) |=> (!enq_valid || $stable(enq_bits)));
    end

endmodule

// File: rtl/tl_buffer_param.sv
// Parametrised TileLink-UL buffer between a client (in) and a manager (out).
// The A channel (in->out) and D channel (out->in) each get an independent
// queue; the two never stall each other.
//
// Handshake: a beat moves when valid && ready at a rising clock edge. valid
// never depends on ready, and bits stay stable while valid && !ready. With
// PIPE=1 a full queue's enq ready follows its deq ready combinationally.
module tl_buffer_param
    import tl_buffer_pkg::*;
#(
    parameter int A_DEPTH  = 2,
    parameter int D_DEPTH  = 2,
    parameter int A_FLOW   = 0,
    parameter int D_FLOW   = 0,
    parameter int A_PIPE   = 0,
    parameter int D_PIPE   = 0,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 64,
    parameter int SOURCE_W = 10,
    parameter int SIZE_W   = 2,
    parameter int SINK_W   = 1
) (
    input  logic                                                   clock,
    input  logic                                                   reset,
    input  logic                                                   in_a_valid,
    output logic                                                   in_a_ready,
    input  logic [tl_a_width(ADDR_W, DATA_W, SOURCE_W, SIZE_W)-1:0] in_a_bits,
    output logic                                                   out_a_valid,
    input  logic                                                   out_a_ready,
    output logic [tl_a_width(ADDR_W, DATA_W, SOURCE_W, SIZE_W)-1:0] out_a_bits,
    input  logic                                                   out_d_valid,
    output logic                                                   out_d_ready,
    input  logic [tl_d_width(DATA_W, SOURCE_W, SIZE_W, SINK_W)-1:0] out_d_bits,
    output logic                                                   in_d_valid,
    input  logic                                                   in_d_ready,
    output logic [tl_d_width(DATA_W, SOURCE_W, SIZE_W, SINK_W)-1:0] in_d_bits,
    output logic [tl_count_width(A_DEPTH)-1:0]                     a_count,
    output logic [tl_count_width(D_DEPTH)-1:0]                     d_count
);

    // Beat layouts at this instance's widths; every field is carried end to end.
    typedef struct packed {
        logic [2:0]            opcode;
        logic [2:0]            param;
        logic [SIZE_W-1:0]     size;
        logic [SOURCE_W-1:0]   source;
        logic [ADDR_W-1:0]     address;
        logic [DATA_W/8-1:0]   mask;
        logic [DATA_W-1:0]     data;
        logic                  corrupt;
    } a_beat_t;

    typedef struct packed {
        logic [2:0]            opcode;
        logic [1:0]            param;
        logic [SIZE_W-1:0]     size;
        logic [SOURCE_W-1:0]   source;
        logic [SINK_W-1:0]     sink;
        logic                  denied;
        logic [DATA_W-1:0]     data;
        logic                  corrupt;
    } d_beat_t;

    tl_queue #(
        .DEPTH (A_DEPTH),
        .FLOW  (A_FLOW),
        .PIPE  (A_PIPE),
        .T     (a_beat_t)
    ) u_a_queue (
        .clk       (clock),
        .rst       (reset),
        .enq_valid (in_a_valid),
        .enq_ready (in_a_ready),
        .enq_bits  (in_a_bits),
        .deq_valid (out_a_valid),
        .deq_ready (out_a_ready),
        .deq_bits  (out_a_bits),
        .count     (a_count)
    );

    tl_queue #(
        .DEPTH (D_DEPTH),
        .FLOW  (D_FLOW),
        .PIPE  (D_PIPE),
        .T     (d_beat_t)
    ) u_d_queue (
        .clk       (clock),
        .rst       (reset),
        .enq_valid (out_d_valid),
        .enq_ready (out_d_ready),
        .enq_bits  (out_d_bits),
        .deq_valid (in_d_valid),
        .deq_ready (in_d_ready),
        .deq_bits  (in_d_bits),
        .count     (d_count)
    );

endmodule

// File: tb/tb_tl_buffer_param.sv
// Bench for tl_buffer_param: three instances cover the buffered, pipe/flow
// and wire-through configurations.
module tb_tl_buffer_param;
    import tl_buffer_pkg::*;

    localparam int A_W = $bits(tl_a_t);
    localparam int D_W = $bits(tl_d_t);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // u0: A depth 2 plain, D depth 3 (non power of two)
    logic u0_in_a_valid, u0_in_a_ready, u0_out_a_valid, u0_out_a_ready;
    logic u0_out_d_valid, u0_out_d_ready, u0_in_d_valid, u0_in_d_ready;
    tl_a_t u0_in_a_bits;
    tl_d_t u0_out_d_bits;
    logic [A_W-1:0] u0_out_a_bits;
    logic [D_W-1:0] u0_in_d_bits;
    logic [1:0] u0_a_count, u0_d_count;

    // u1: A depth 2 with PIPE, D depth 2 with FLOW
    logic u1_in_a_valid, u1_in_a_ready, u1_out_a_valid, u1_out_a_ready;
    logic u1_out_d_valid, u1_out_d_ready, u1_in_d_valid, u1_in_d_ready;
    tl_a_t u1_in_a_bits;
    tl_d_t u1_out_d_bits;
    logic [A_W-1:0] u1_out_a_bits;
    logic [D_W-1:0] u1_in_d_bits;
    logic [1:0] u1_a_count, u1_d_count;

    // u2: both channels wire-through
    logic u2_in_a_valid, u2_in_a_ready, u2_out_a_valid, u2_out_a_ready;
    logic u2_out_d_valid, u2_out_d_ready, u2_in_d_valid, u2_in_d_ready;
    tl_a_t u2_in_a_bits;
    tl_d_t u2_out_d_bits;
    logic [A_W-1:0] u2_out_a_bits;
    logic [D_W-1:0] u2_in_d_bits;
    logic [0:0] u2_a_count, u2_d_count;

    tl_buffer_param #(.A_DEPTH(2), .D_DEPTH(3)) u0 (
        .clock(clk), .reset(rst),
        .in_a_valid(u0_in_a_valid), .in_a_ready(u0_in_a_ready), .in_a_bits(u0_in_a_bits),
        .out_a_valid(u0_out_a_valid), .out_a_ready(u0_out_a_ready), .out_a_bits(u0_out_a_bits),
        .out_d_valid(u0_out_d_valid), .out_d_ready(u0_out_d_ready), .out_d_bits(u0_out_d_bits),
        .in_d_valid(u0_in_d_valid), .in_d_ready(u0_in_d_ready), .in_d_bits(u0_in_d_bits),
        .a_count(u0_a_count), .d_count(u0_d_count)
    );

    tl_buffer_param #(.A_DEPTH(2), .A_PIPE(1), .D_DEPTH(2), .D_FLOW(1)) u1 (
        .clock(clk), .reset(rst),
        .in_a_valid(u1_in_a_valid), .in_a_ready(u1_in_a_ready), .in_a_bits(u1_in_a_bits),
        .out_a_valid(u1_out_a_valid), .out_a_ready(u1_out_a_ready), .out_a_bits(u1_out_a_bits),
        .out_d_valid(u1_out_d_valid), .out_d_ready(u1_out_d_ready), .out_d_bits(u1_out_d_bits),
        .in_d_valid(u1_in_d_valid), .in_d_ready(u1_in_d_ready), .in_d_bits(u1_in_d_bits),
        .a_count(u1_a_count), .d_count(u1_d_count)
    );

    tl_buffer_param #(.A_DEPTH(0), .D_DEPTH(0)) u2 (
        .clock(clk), .reset(rst),
        .in_a_valid(u2_in_a_valid), .in_a_ready(u2_in_a_ready), .in_a_bits(u2_in_a_bits),
        .out_a_valid(u2_out_a_valid), .out_a_ready(u2_out_a_ready), .out_a_bits(u2_out_a_bits),
        .out_d_valid(u2_out_d_valid), .out_d_ready(u2_out_d_ready), .out_d_bits(u2_out_d_bits),
        .in_d_valid(u2_in_d_valid), .in_d_ready(u2_in_d_ready), .in_d_bits(u2_in_d_bits),
        .a_count(u2_a_count), .d_count(u2_d_count)
    );

    // ---------------- scoreboard ----------------
    logic [A_W-1:0] u0_exp_a[$];
    logic [D_W-1:0] u0_exp_d[$];
    logic [A_W-1:0] u1_exp_a[$];
    logic [D_W-1:0] u1_exp_d[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every beat leaving a queue against the oldest expected beat.
    always @(negedge clk) begin
        if (!rst && u0_out_a_valid && u0_out_a_ready) begin
            if (u0_exp_a.size() == 0) chk("u0_a_unexpected_beat", u0_out_a_valid, 1'b0);
            else chk("u0_a_order", u0_out_a_bits, u0_exp_a.pop_front());
        end
        if (!rst && u0_in_d_valid && u0_in_d_ready) begin
            if (u0_exp_d.size() == 0) chk("u0_d_unexpected_beat", u0_in_d_valid, 1'b0);
            else chk("u0_d_order", u0_in_d_bits, u0_exp_d.pop_front());
        end
        if (!rst && u1_out_a_valid && u1_out_a_ready) begin
            if (u1_exp_a.size() == 0) chk("u1_a_unexpected_beat", u1_out_a_valid, 1'b0);
            else chk("u1_a_order", u1_out_a_bits, u1_exp_a.pop_front());
        end
        if (!rst && u1_in_d_valid && u1_in_d_ready) begin
            if (u1_exp_d.size() == 0) chk("u1_d_unexpected_beat", u1_in_d_valid, 1'b0);
            else chk("u1_d_order", u1_in_d_bits, u1_exp_d.pop_front());
        end
    end

    // ---------------- beat builders ----------------
    function automatic tl_a_t mk_a(input int src);
        tl_a_t a;
        a         = '0;
        a.opcode  = TL_A_GET;
        a.size    = 2'd3;
        a.source  = src[9:0];
        a.address = $urandom;
        a.mask    = '1;
        a.data    = {$urandom, $urandom};
        return a;
    endfunction

    function automatic tl_d_t mk_d(input int src, input logic denied);
        tl_d_t d;
        d         = '0;
        d.opcode  = TL_D_ACCESS_ACK_DATA;
        d.param   = src[1:0];
        d.size    = 2'd3;
        d.source  = src[9:0];
        d.sink    = src[0];
        d.denied  = denied;
        d.data    = {$urandom, $urandom};
        d.corrupt = src[1];
        return d;
    endfunction

    // ---------------- driver tasks ----------------
    // Each send starts just after a rising edge and returns just after the
    // edge that accepted the beat.
    task automatic send_u0_a(input tl_a_t b);
        u0_in_a_bits  = b;
        u0_in_a_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (u0_in_a_ready) begin
                u0_exp_a.push_back(b);
                @(posedge clk); #1;
                u0_in_a_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        chk("u0_a_send_timeout", u0_in_a_ready, 1'b1);
        u0_in_a_valid = 1'b0;
    endtask

    task automatic send_u0_d(input tl_d_t b);
        u0_out_d_bits  = b;
        u0_out_d_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (u0_out_d_ready) begin
                u0_exp_d.push_back(b);
                @(posedge clk); #1;
                u0_out_d_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        chk("u0_d_send_timeout", u0_out_d_ready, 1'b1);
        u0_out_d_valid = 1'b0;
    endtask

    task automatic send_u1_a(input tl_a_t b);
        u1_in_a_bits  = b;
        u1_in_a_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (u1_in_a_ready) begin
                u1_exp_a.push_back(b);
                @(posedge clk); #1;
                u1_in_a_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        chk("u1_a_send_timeout", u1_in_a_ready, 1'b1);
        u1_in_a_valid = 1'b0;
    endtask

    task automatic drain_u0_a();
        for (int n = 0; n < 30 && u0_exp_a.size() != 0; n++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain_u1_a();
        for (int n = 0; n < 30 && u1_exp_a.size() != 0; n++) begin
            @(posedge clk); #1;
        end
    endtask

    // ---------------- directed sequence ----------------
    tl_d_t d_beats [10];
    tl_d_t dbeat;
    tl_a_t abeat;
    int    sent;

    initial begin
        u0_in_a_valid = 0; u0_out_a_ready = 0; u0_out_d_valid = 0; u0_in_d_ready = 0;
        u1_in_a_valid = 0; u1_out_a_ready = 0; u1_out_d_valid = 0; u1_in_d_ready = 0;
        u2_in_a_valid = 0; u2_out_a_ready = 0; u2_out_d_valid = 0; u2_in_d_ready = 0;
        u0_in_a_bits = '0; u0_out_d_bits = '0; u1_in_a_bits = '0; u1_out_d_bits = '0;
        u2_in_a_bits = '0; u2_out_d_bits = '0;
        rst = 1'b1;

        // Reset state: readys forced low, counts and valids zero.
        @(negedge clk);
        chk("rst_u0_in_a_ready", u0_in_a_ready, 1'b0);
        chk("rst_u0_out_d_ready", u0_out_d_ready, 1'b0);
        chk("rst_u0_a_count", u0_a_count, 2'd0);
        chk("rst_u0_out_a_valid", u0_out_a_valid, 1'b0);
        chk("rst_u1_in_d_valid", u1_in_d_valid, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rel_u0_in_a_ready", u0_in_a_ready, 1'b1);
        chk("rel_u0_out_d_ready", u0_out_d_ready, 1'b1);
        @(posedge clk); #1;

        // Test 1: three Gets into a 2-deep A queue with the manager stalled.
        send_u0_a(mk_a(1));
        chk("t1_count_after_1", u0_a_count, 2'd1);
        chk("t1_latency_valid", u0_out_a_valid, 1'b1);
        send_u0_a(mk_a(2));
        chk("t1_count_after_2", u0_a_count, 2'd2);
        abeat = mk_a(3);
        u0_in_a_bits  = abeat;
        u0_in_a_valid = 1'b1;
        @(negedge clk);
        chk("t1_full_ready", u0_in_a_ready, 1'b0);
        chk("t1_full_count", u0_a_count, 2'd2);
        @(posedge clk); #1;
        u0_out_a_ready = 1'b1;
        @(negedge clk);
        chk("t1_full_nopipe_ready", u0_in_a_ready, 1'b0);
        @(posedge clk); #1;
        send_u0_a(abeat);
        drain_u0_a();
        chk("t1_drained_queue", u0_exp_a.size(), 0);
        chk("t1_drained_count", u0_a_count, 2'd0);

        // Test 4: ten D beats through a 3-deep queue under random ready.
        for (int i = 0; i < 10; i++) d_beats[i] = mk_d(i + 16, i[0]);
        sent = 0;
        for (int n = 0; n < 300 && (sent < 10 || u0_exp_d.size() != 0); n++) begin
            chk("t4_d_count", u0_d_count, u0_exp_d.size());
            u0_in_d_ready = 1'($urandom_range(0, 1));
            if (sent < 10) begin
                u0_out_d_bits  = d_beats[sent];
                u0_out_d_valid = 1'b1;
            end else begin
                u0_out_d_valid = 1'b0;
            end
            @(negedge clk);
            if (u0_out_d_valid && u0_out_d_ready) begin
                u0_exp_d.push_back(d_beats[sent]);
                sent++;
            end
            @(posedge clk); #1;
        end
        u0_out_d_valid = 1'b0;
        chk("t4_all_sent", sent, 10);
        chk("t4_drained", u0_exp_d.size(), 0);
        chk("t4_final_count", u0_d_count, 2'd0);

        // Test 5: asynchronous reset with beats held in both queues.
        u0_out_a_ready = 1'b0;
        u0_in_d_ready  = 1'b0;
        send_u0_a(mk_a(40));
        send_u0_a(mk_a(41));
        send_u0_d(mk_d(42, 1'b0));
        chk("t5_pre_a_count", u0_a_count, 2'd2);
        chk("t5_pre_d_count", u0_d_count, 2'd1);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("t5_a_count", u0_a_count, 2'd0);
        chk("t5_d_count", u0_d_count, 2'd0);
        chk("t5_out_a_valid", u0_out_a_valid, 1'b0);
        chk("t5_in_d_valid", u0_in_d_valid, 1'b0);
        chk("t5_in_a_ready", u0_in_a_ready, 1'b0);
        chk("t5_out_d_ready", u0_out_d_ready, 1'b0);
        u0_exp_a.delete();
        u0_exp_d.delete();
        // Offer beats across a reset edge; neither may be taken.
        u0_in_a_bits   = mk_a(43);
        u0_in_a_valid  = 1'b1;
        u0_out_d_bits  = mk_d(44, 1'b0);
        u0_out_d_valid = 1'b1;
        @(posedge clk); #1;
        chk("t5_hold_in_a_ready", u0_in_a_ready, 1'b0);
        chk("t5_hold_a_count", u0_a_count, 2'd0);
        chk("t5_hold_d_count", u0_d_count, 2'd0);
        u0_in_a_valid  = 1'b0;
        u0_out_d_valid = 1'b0;
        #1;
        rst = 1'b0;
        u0_out_a_ready = 1'b1;
        u0_in_d_ready  = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("t5_no_stale_a", u0_out_a_valid, 1'b0);
        chk("t5_no_stale_d", u0_in_d_valid, 1'b0);
        chk("t5_ready_back", u0_in_a_ready, 1'b1);
        @(posedge clk); #1;

        // Test 2: full PIPE queue streams one beat per cycle.
        send_u1_a(mk_a(60));
        send_u1_a(mk_a(61));
        chk("t2_full_count", u1_a_count, 2'd2);
        abeat = mk_a(62);
        u1_in_a_bits  = abeat;
        u1_in_a_valid = 1'b1;
        @(negedge clk);
        chk("t2_full_stalled_ready", u1_in_a_ready, 1'b0);
        @(posedge clk); #1;
        u1_out_a_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i != 0) begin
                abeat = mk_a(62 + i);
                u1_in_a_bits = abeat;
            end
            @(negedge clk);
            chk("t2_pipe_ready", u1_in_a_ready, 1'b1);
            chk("t2_pipe_count", u1_a_count, 2'd2);
            if (u1_in_a_ready) u1_exp_a.push_back(abeat);
            @(posedge clk); #1;
        end
        u1_in_a_valid = 1'b0;
        drain_u1_a();
        chk("t2_drained_queue", u1_exp_a.size(), 0);
        chk("t2_drained_count", u1_a_count, 2'd0);

        // Test 3: FLOW D queue passes a beat through in the same cycle.
        u1_in_d_ready = 1'b1;
        dbeat = '0;
        dbeat.opcode = TL_D_ACCESS_ACK_DATA;
        dbeat.size   = 2'd3;
        dbeat.source = 10'd7;
        dbeat.sink   = 1'b1;
        dbeat.denied = 1'b1;
        dbeat.data   = 64'h0000_0000_DEAD_BEEF;
        u1_out_d_bits  = dbeat;
        u1_exp_d.push_back(dbeat);
        u1_out_d_valid = 1'b1;
        #1;
        chk("t3_flow_valid", u1_in_d_valid, 1'b1);
        chk("t3_flow_bits", u1_in_d_bits, dbeat);
        chk("t3_flow_count", u1_d_count, 2'd0);
        @(posedge clk); #1;
        u1_out_d_valid = 1'b0;
        chk("t3_bypass_count", u1_d_count, 2'd0);
        // Same queue, client stalled: the beat is shown and also stored.
        u1_in_d_ready = 1'b0;
        dbeat = mk_d(9, 1'b0);
        u1_out_d_bits  = dbeat;
        u1_exp_d.push_back(dbeat);
        u1_out_d_valid = 1'b1;
        #1;
        chk("t3_stall_valid", u1_in_d_valid, 1'b1);
        @(posedge clk); #1;
        u1_out_d_valid = 1'b0;
        #1;
        chk("t3_stored_count", u1_d_count, 2'd1);
        chk("t3_stored_bits", u1_in_d_bits, dbeat);
        u1_in_d_ready = 1'b1;
        @(posedge clk); #1;
        chk("t3_drained_count", u1_d_count, 2'd0);
        chk("t3_drained_queue", u1_exp_d.size(), 0);

        // Test 6: zero-depth instance is pure wires.
        for (int i = 0; i < 4; i++) begin
            u2_in_a_valid  = 1'($urandom_range(0, 1));
            u2_out_a_ready = 1'($urandom_range(0, 1));
            u2_out_d_valid = 1'($urandom_range(0, 1));
            u2_in_d_ready  = 1'($urandom_range(0, 1));
            u2_in_a_bits   = mk_a(100 + i);
            u2_out_d_bits  = mk_d(200 + i, i[0]);
            #1;
            chk("t6_out_a_valid", u2_out_a_valid, u2_in_a_valid);
            chk("t6_in_a_ready", u2_in_a_ready, u2_out_a_ready);
            chk("t6_out_a_bits", u2_out_a_bits, u2_in_a_bits);
            chk("t6_in_d_valid", u2_in_d_valid, u2_out_d_valid);
            chk("t6_out_d_ready", u2_out_d_ready, u2_in_d_ready);
            chk("t6_in_d_bits", u2_in_d_bits, u2_out_d_bits);
            chk("t6_a_count", u2_a_count, 1'b0);
            chk("t6_d_count", u2_d_count, 1'b0);
            @(posedge clk); #1;
        end

        // ---------------- final report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
